demux2vec_buf: RTL and testbench

Buffered 1-to-2 vector demultiplexer with valid/ready handshakes. It accepts one vector of DEPTH lanes of WIDTH bits and routes it to one of two destination channels, chosen by a 1-bit select. Each channel has its own 2-entry FIFO, so one channel stalling does not block traffic already buffered for the other. It sits in the vector datapath where one producer (e.g. vector register read or ALU result) fans out to two consumers (e.g. memory write path vs. writeback).

---
 rtl/demux2vec_buf.sv | 129 ++++++++++++
 tb/tb_demux2vec_buf.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux2vec_buf.sv
// demux2vec_buf
//   Buffered 1-to-2 vector demultiplexer. One incoming vector of DEPTH lanes
//   of WIDTH bits is steered by in_sel into one of two channels. Each channel
//   owns a 2-entry FIFO, so a stalled consumer only blocks producer traffic
//   aimed at its own channel.
//
// Ports
//   clk                    single clock, rising-edge
//   rst                    asynchronous, active-low reset
//   in_data [0:DEPTH-1]    input vector
//   in_sel                 destination channel (0 or 1)
//   in_valid / in_ready    producer handshake (in_ready = rst && target not full)
//   outN_data [0:DEPTH-1]  head entry of channel N FIFO (registered)
//   outN_valid / outN_ready consumer handshake for channel N
//   cntN                   accepted-vector count for channel N, wraps
module demux2vec_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data [0:DEPTH-1],
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data [0:DEPTH-1],
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data [0:DEPTH-1],
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  // Per-channel state: occupancy (0..2), head slot index, two data slots,
  // accepted-vector counter.
  logic [1:0]       occ_q  [0:1];
  logic [1:0]       occ_d  [0:1];
  logic [1:0]       head_q;
  logic [1:0]       head_d;
  logic [WIDTH-1:0] slot_q [0:1][0:1][0:DEPTH-1];
  logic [WIDTH-1:0] slot_d [0:1][0:1][0:DEPTH-1];
  logic [CNT_W-1:0] cnt_q  [0:1];
  logic [CNT_W-1:0] cnt_d  [0:1];

  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;
  logic       accept;

  assign out_ready = {out1_ready, out0_ready};

  // Only combinational path of the block: in_sel selects which occupancy
  // gates in_ready. Consumer readiness is deliberately not involved.
  assign in_ready = rst && (occ_q[in_sel] != 2'd2);
  assign accept   = in_valid && in_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    slot_d = slot_q;
    cnt_d  = cnt_q;
    push   = 2'b00;
    pop    = 2'b00;
    for (int c = 0; c < 2; c++) begin
      push[c] = accept && (in_sel == c[0]);
      pop[c]  = (occ_q[c] != 2'd0) && out_ready[c];

      // Write slot: the head when empty, the other slot when one entry held.
      // A push is never presented when full.
      if (push[c]) begin
        for (int l = 0; l < DEPTH; l++) begin
          slot_d[c][head_q[c] ^ occ_q[c][0]][l] = in_data[l];
        end
        cnt_d[c] = cnt_q[c] + 1'b1;
      end

      // The head only advances when another entry remains to take its place.
      // Popping the last entry leaves the head where it is, so outN_data keeps
      // showing the last delivered vector while the channel is empty.
      if (pop[c] && (occ_q[c] == 2'd2 || push[c])) begin
        head_d[c] = ~head_q[c];
      end

      occ_d[c] = occ_q[c] + {1'b0, push[c]} - {1'b0, pop[c]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        occ_q[c] <= 2'd0;
        cnt_q[c] <= '0;
        for (int s = 0; s < 2; s++) begin
          for (int l = 0; l < DEPTH; l++) begin
            slot_q[c][s][l] <= '0;
          end
        end
      end
    end else begin
      head_q <= head_d;
      for (int c = 0; c < 2; c++) begin
        occ_q[c] <= occ_d[c];
        cnt_q[c] <= cnt_d[c];
        for (int s = 0; s < 2; s++) begin
          for (int l = 0; l < DEPTH; l++) begin
            slot_q[c][s][l] <= slot_d[c][s][l];
          end
        end
      end
    end
  end

  assign out0_valid = (occ_q[0] != 2'd0);
  assign out1_valid = (occ_q[1] != 2'd0);
  assign cnt0       = cnt_q[0];
  assign cnt1       = cnt_q[1];

  always_comb begin
    for (int l = 0; l < DEPTH; l++) begin
      out0_data[l] = slot_q[0][head_q[0]][l];
      out1_data[l] = slot_q[1][head_q[1]][l];
    end
  end

endmodule

// File: tb/tb_demux2vec_buf.sv
// tb_demux2vec_buf
//   Directed bench for demux2vec_buf: reset/idle, routing, backpressure,
//   streaming push+pop, counter wrap and mid-stream reset.
module tb_demux2vec_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int VW    = WIDTH * DEPTH;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data [0:DEPTH-1];
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data [0:DEPTH-1];
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data [0:DEPTH-1];
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int n_cmp;
  int n_err;

  demux2vec_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Lane 0 lands in the most significant word.
  function automatic logic [VW-1:0] pk0();
    logic [VW-1:0] r;
    for (int l = 0; l < DEPTH; l++) r[VW-1-l*WIDTH -: WIDTH] = out0_data[l];
    return r;
  endfunction

  function automatic logic [VW-1:0] pk1();
    logic [VW-1:0] r;
    for (int l = 0; l < DEPTH; l++) r[VW-1-l*WIDTH -: WIDTH] = out1_data[l];
    return r;
  endfunction

  function automatic logic [VW-1:0] vec(input int a, input int b, input int c, input int d);
    return {a[WIDTH-1:0], b[WIDTH-1:0], c[WIDTH-1:0], d[WIDTH-1:0]};
  endfunction

  task automatic drive(input int a, input int b, input int c, input int d, input logic sel);
    in_data[0] = a[WIDTH-1:0];
    in_data[1] = b[WIDTH-1:0];
    in_data[2] = c[WIDTH-1:0];
    in_data[3] = d[WIDTH-1:0];
    in_sel     = sel;
    in_valid   = 1'b1;
  endtask

  // Advance one active edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [CNT_W-1:0] exp_c1;

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(9, 9, 9, 9, 1'b0);

    // ---------------- reset / idle ----------------
    #3;
    check("rst_in_ready", VW'(in_ready), VW'(0));
    check("rst_v0", VW'(out0_valid), VW'(0));
    check("rst_v1", VW'(out1_valid), VW'(0));
    check("rst_cnt0", VW'(cnt0), VW'(0));
    check("rst_cnt1", VW'(cnt1), VW'(0));
    tick();
    tick();
    check("rst_hold_v0", VW'(out0_valid), VW'(0));
    in_valid = 1'b0;
    #2 rst = 1'b1;
    tick();
    tick();
    check("idle_v0", VW'(out0_valid), VW'(0));
    check("idle_v1", VW'(out1_valid), VW'(0));
    check("idle_cnt0", VW'(cnt0), VW'(0));

    // ---------------- routing ----------------
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1, 2, 3, 4, 1'b0);
    #1 check("rt_in_ready", VW'(in_ready), VW'(1));
    tick();
    check("rt_v0", VW'(out0_valid), VW'(1));
    check("rt_d0", pk0(), vec(1, 2, 3, 4));
    check("rt_v1_idle", VW'(out1_valid), VW'(0));
    drive(5, 6, 7, 8, 1'b1);
    tick();
    check("rt_v0_popped", VW'(out0_valid), VW'(0));
    check("rt_v1", VW'(out1_valid), VW'(1));
    check("rt_d1", pk1(), vec(5, 6, 7, 8));
    in_valid = 1'b0;
    tick();
    check("rt_v1_popped", VW'(out1_valid), VW'(0));
    check("rt_cnt0", VW'(cnt0), VW'(1));
    check("rt_cnt1", VW'(cnt1), VW'(1));

    // ---------------- backpressure ----------------
    out0_ready = 1'b0;
    drive(16'hA0, 16'hA1, 16'hA2, 16'hA3, 1'b0);
    tick();
    drive(16'hB0, 16'hB1, 16'hB2, 16'hB3, 1'b0);
    tick();
    drive(16'hC0, 16'hC1, 16'hC2, 16'hC3, 1'b0);
    #1 check("bp_full_in_ready", VW'(in_ready), VW'(0));
    tick();
    check("bp_cnt0_stalled", VW'(cnt0), VW'(3));
    check("bp_head_A", pk0(), vec(16'hA0, 16'hA1, 16'hA2, 16'hA3));
    drive(16'hD0, 16'hD1, 16'hD2, 16'hD3, 1'b1);
    #1 check("bp_other_in_ready", VW'(in_ready), VW'(1));
    tick();
    check("bp_v1", VW'(out1_valid), VW'(1));
    check("bp_d1", pk1(), vec(16'hD0, 16'hD1, 16'hD2, 16'hD3));
    check("bp_cnt1", VW'(cnt1), VW'(2));
    drive(16'hC0, 16'hC1, 16'hC2, 16'hC3, 1'b0);
    out0_ready = 1'b1;
    #1 check("bp_still_full", VW'(in_ready), VW'(0));
    tick();
    check("bp_head_B", pk0(), vec(16'hB0, 16'hB1, 16'hB2, 16'hB3));
    check("bp_recover", VW'(in_ready), VW'(1));
    check("bp_v1_drained", VW'(out1_valid), VW'(0));
    tick();
    check("bp_head_C", pk0(), vec(16'hC0, 16'hC1, 16'hC2, 16'hC3));
    check("bp_cnt0", VW'(cnt0), VW'(4));
    in_valid = 1'b0;
    tick();
    check("bp_v0_drained", VW'(out0_valid), VW'(0));

    // ---------------- streaming push+pop ----------------
    for (int i = 0; i < 6; i++) begin
      drive(100 + i, 200 + i, 300 + i, 400 + i, 1'b0);
      tick();
      check($sformatf("st_v0_%0d", i), VW'(out0_valid), VW'(1));
      check($sformatf("st_d0_%0d", i), pk0(), vec(100 + i, 200 + i, 300 + i, 400 + i));
    end
    in_valid = 1'b0;
    tick();
    check("st_v0_end", VW'(out0_valid), VW'(0));
    check("st_hold_data", pk0(), vec(105, 205, 305, 405));
    check("st_cnt0", VW'(cnt0), VW'(10));

    // ---------------- counter wrap on channel 1 ----------------
    exp_c1 = 8'd2;
    for (int i = 0; i < 256; i++) begin
      drive(i, i, i, i, 1'b1);
      tick();
      exp_c1 = exp_c1 + 8'd1;
      if (exp_c1 == 8'd0) check("wr_cnt1_zero", VW'(cnt1), VW'(0));
    end
    in_valid = 1'b0;
    check("wr_cnt1_final", VW'(cnt1), VW'(exp_c1));
    check("wr_cnt0_unch", VW'(cnt0), VW'(10));
    tick();

    // ---------------- mid-stream reset ----------------
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(11, 11, 11, 11, 1'b0); tick();
    drive(12, 12, 12, 12, 1'b0); tick();
    drive(21, 21, 21, 21, 1'b1); tick();
    drive(22, 22, 22, 22, 1'b1); tick();
    check("mr_full1_in_ready", VW'(in_ready), VW'(0));
    in_sel = 1'b0;
    #1 check("mr_full0_in_ready", VW'(in_ready), VW'(0));
    check("mr_v0", VW'(out0_valid), VW'(1));
    check("mr_v1", VW'(out1_valid), VW'(1));
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("mr_v0_drop", VW'(out0_valid), VW'(0));
    check("mr_v1_drop", VW'(out1_valid), VW'(0));
    check("mr_cnt0", VW'(cnt0), VW'(0));
    check("mr_cnt1", VW'(cnt1), VW'(0));
    check("mr_in_ready", VW'(in_ready), VW'(0));
    #1 rst = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    tick();
    tick();
    check("mr_post_v0", VW'(out0_valid), VW'(0));
    check("mr_post_v1", VW'(out1_valid), VW'(0));
    check("mr_post_d0", pk0(), vec(0, 0, 0, 0));
    check("mr_post_d1", pk1(), vec(0, 0, 0, 0));
    check("mr_post_cnt1", VW'(cnt1), VW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
